// File: rtl/global_hit_reader.sv
// Global-side hit reader: broadcasts L1 tag, drains matched hits, frames output.
// Optional trigger-hit capture under `define TRIG_CAPTURE_EN.
module global_hit_reader #(
  parameter int BCSTWIDTH  = 27,
  parameter int SETTLE_CYC = 2,
  parameter int MAXHITS    = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 l1aValid,
  input  logic [BCSTWIDTH-2:0] l1aTag,
  output logic                 l1aReady,
  input  logic [45:0]          dnData,
  input  logic                 dnUnreadHit,
  output logic                 dnRead,
  output logic [BCSTWIDTH-1:0] dnBCST,
  output logic [47:0]          outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 busy,
  input  logic [4:0]           trigDataSize,
  input  logic [15:0]          trigHits,
  output logic [15:0]          trigOut
);

  localparam int TW = BCSTWIDTH - 1;

  typedef enum logic [2:0] {
    IDLE, HDR, SETTLE, CHECK, HIT, GAP, TRL
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [TW-1:0]        r_tag;
  logic [7:0]           r_cnt;
  logic                 r_trunc;
  logic [3:0]           r_settle;
  logic [BCSTWIDTH-1:0] r_bcst;
  logic [45:0]          w_hdr_pl;
  logic [45:0]          w_trl_pl;
  logic                 w_settled;
  logic                 w_full;

  assign w_hdr_pl  = 46'(r_tag);
  assign w_trl_pl  = 46'({r_trunc, r_cnt, r_tag});
  assign w_settled = (r_settle == 4'(SETTLE_CYC - 1));
  assign w_full    = (r_cnt == 8'(MAXHITS));
  assign dnBCST    = r_bcst;

  always_comb begin
    w_next   = r_state;
    outValid = 1'b0;
    outData  = '0;
    dnRead   = 1'b0;
    l1aReady = 1'b0;
    busy     = 1'b1;
    unique case (r_state)
      IDLE: begin
        l1aReady = 1'b1;
        busy     = 1'b0;
        if (l1aValid) w_next = HDR;
      end
      HDR: begin
        outValid = 1'b1;
        outData  = {2'b10, w_hdr_pl};
        if (outReady) w_next = SETTLE;
      end
      SETTLE: begin
        if (w_settled) w_next = CHECK;
      end
      CHECK: begin
        if (!dnUnreadHit || w_full) w_next = TRL;
        else                        w_next = HIT;
      end
      HIT: begin
        outValid = 1'b1;
        outData  = {2'b00, dnData};
        dnRead   = outReady;
        if (outReady) w_next = GAP;
      end
      GAP: w_next = CHECK;
      TRL: begin
        outValid = 1'b1;
        outData  = {2'b11, w_trl_pl};
        if (outReady) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_tag    <= '0;
      r_cnt    <= '0;
      r_trunc  <= 1'b0;
      r_settle <= '0;
      r_bcst   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (l1aValid) begin
            r_tag   <= l1aTag;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
          end
        end
        HDR: begin
          if (outReady) begin
            r_bcst   <= {1'b1, r_tag};
            r_settle <= '0;
          end
        end
        SETTLE: r_settle <= r_settle + 4'd1;
        CHECK: begin
          if (dnUnreadHit && w_full) r_trunc <= 1'b1;
        end
        HIT: begin
          if (outReady) r_cnt <= r_cnt + 8'd1;
        end
        TRL: begin
          // tag bits keep the last event's tag
          if (outReady) r_bcst[BCSTWIDTH-1] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef TRIG_CAPTURE_EN
  logic [15:0] r_trig;
  logic [15:0] w_mask;

  always_comb begin
    w_mask = '0;
    unique case (trigDataSize)
      5'd1:    w_mask = 16'h0001;
      5'd2:    w_mask = 16'h0003;
      5'd4:    w_mask = 16'h000F;
      5'd8:    w_mask = 16'h00FF;
      5'd16:   w_mask = 16'hFFFF;
      default: w_mask = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_trig <= '0;
    else       r_trig <= trigHits & w_mask;
  end

  assign trigOut = r_trig;
`else
  logic w_unused_trig;
  assign w_unused_trig = ^{trigDataSize, trigHits};
  assign trigOut       = '0;
`endif

endmodule

// File: tb/tb_global_hit_reader.sv
// Scoreboard bench for global_hit_reader: pixel queue model, framed-output checks.
module tb_global_hit_reader;

  localparam int BW   = 27;
  localparam int TW   = BW - 1;
  localparam int MAXH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          l1aValid;
  logic [TW-1:0] l1aTag;
  logic          l1aReady;
  logic [45:0]   dnData;
  logic          dnUnreadHit;
  logic          dnRead;
  logic [BW-1:0] dnBCST;
  logic [47:0]   outData;
  logic          outValid;
  logic          outReady;
  logic          busy;
  logic [4:0]    trigDataSize;
  logic [15:0]   trigHits;
  logic [15:0]   trigOut;

  always #5 clk = ~clk;

  global_hit_reader #(
    .BCSTWIDTH (BW),
    .SETTLE_CYC(2),
    .MAXHITS   (MAXH)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .l1aValid    (l1aValid),
    .l1aTag      (l1aTag),
    .l1aReady    (l1aReady),
    .dnData      (dnData),
    .dnUnreadHit (dnUnreadHit),
    .dnRead      (dnRead),
    .dnBCST      (dnBCST),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady),
    .busy        (busy),
    .trigDataSize(trigDataSize),
    .trigHits    (trigHits),
    .trigOut     (trigOut)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [47:0]   sb[$];
  logic [45:0]   pix[$];
  int            mode = 0;
  int            rd_cnt = 0;
  int            cyc = 0;
  int            last_rd = -100;
  logic          rd_now = 1'b0;
  logic          held_v = 1'b0;
  logic [47:0]   held;
  logic [TW-1:0] cur_tag = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // pixel model outputs, outReady driver and output monitor
  always @(negedge clk) begin
    cyc++;
    dnUnreadHit = (pix.size() != 0);
    dnData      = (pix.size() != 0) ? pix[0] : '0;
    case (mode)
      0:       outReady = 1'b1;
      1:       outReady = 1'($urandom_range(0, 1));
      default: outReady = (outData[47:46] != 2'b00);
    endcase
    #1;
    if (rstn) begin
      if (held_v && outValid) check("hold", outData, held);
      check("dnread", dnRead,
            outValid && outReady && outData[47:46] == 2'b00);
      if (dnRead) begin
        rd_cnt++;
        check("rdgap", (cyc - last_rd) >= 3, 1);
        check("bcst_act", dnBCST, {1'b1, cur_tag});
        last_rd = cyc;
        rd_now  = 1'b1;
      end
      if (outValid && outReady) begin
        if (sb.size() > 0) check("word", outData, sb.pop_front());
        else               check("extra", outData, 48'h0);
      end
      held_v = outValid && !outReady;
      held   = outData;
    end else begin
      held_v = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rd_now) begin
      if (pix.size() > 0) void'(pix.pop_front());
      rd_now = 1'b0;
    end
  end

  task automatic run_event(logic [TW-1:0] tag, int nh, int m);
    int          nout;
    logic        tr;
    logic [45:0] h;
    int          rd0;
    int          t;
    nout = (nh > MAXH) ? MAXH : nh;
    tr   = (nh > MAXH);
    @(negedge clk); #2;
    mode    = m;
    cur_tag = tag;
    rd0     = rd_cnt;
    sb.push_back({2'b10, 46'(tag)});
    for (int i = 0; i < nh; i++) begin
      h = 46'({$urandom(), $urandom()});
      pix.push_back(h);
      if (i < nout) sb.push_back({2'b00, h});
    end
    sb.push_back({2'b11, 46'({tr, 8'(nout), tag})});
    l1aValid = 1'b1;
    l1aTag   = tag;
    @(negedge clk); #2;
    l1aValid = 1'b0;
    check("busy_on", busy, 1);
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk); #2;
      t++;
    end
    check("timeout", busy, 0);
    check("l1a_rdy", l1aReady, 1);
    check("sb_left", sb.size(), 0);
    check("rd_cnt", rd_cnt - rd0, nout);
    check("pix_left", pix.size(), nh - nout);
    check("unread", dnUnreadHit, nh > nout);
    check("bcst_end", dnBCST, {1'b0, tag});
    sb.delete();
    pix.delete();
  endtask

  task automatic reset_outputs_check(string tag);
    check({tag, "_ovld"}, outValid, 0);
    check({tag, "_odat"}, outData, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd"}, dnRead, 0);
    check({tag, "_bcst"}, dnBCST, 0);
    check({tag, "_trig"}, trigOut, 0);
    check({tag, "_rdy"}, l1aReady, 1);
  endtask

  initial begin
    int t;
    rstn         = 1'b0;
    l1aValid     = 1'b0;
    l1aTag       = '0;
    trigDataSize = '0;
    trigHits     = '0;
    repeat (3) @(negedge clk);
    #2;
    reset_outputs_check("rst");
    rstn = 1'b1;

    run_event(26'h155, 0, 0);
    run_event(26'h0ABCDEF, 3, 0);
    run_event(26'h3FFFFFF, 7, 0);
    run_event(26'h1234567, 4, 1);
    run_event(26'h0000001, 2, 1);

    @(negedge clk); #2;
    mode    = 2;
    cur_tag = 26'h2A5A;
    sb.push_back({2'b10, 46'(cur_tag)});
    for (int i = 0; i < 3; i++) pix.push_back(46'(i + 1));
    l1aValid = 1'b1;
    l1aTag   = cur_tag;
    @(negedge clk); #2;
    l1aValid = 1'b0;
    t = 0;
    while (!(outValid && outData[47:46] == 2'b00) && t < 50) begin
      @(negedge clk); #2;
      t++;
    end
    check("reach_hit", outValid && outData[47:46] == 2'b00, 1);
    check("hit_data", outData, {2'b00, 46'd1});
    #1 rstn = 1'b0;
    #1 reset_outputs_check("midrst");
    sb.delete();
    pix.delete();
    @(negedge clk); #2;
    rstn = 1'b1;
    run_event(26'h3C3, 0, 0);
    run_event(26'h3C4, 1, 0);

`ifdef TRIG_CAPTURE_EN
    @(negedge clk);
    trigDataSize = 5'd4;
    trigHits     = 16'hFFFF;
    @(posedge clk); #1;
    check("trig4", trigOut, 16'h000F);
    @(negedge clk);
    trigDataSize = 5'd3;
    @(posedge clk); #1;
    check("trig3", trigOut, 16'h0000);
    @(negedge clk);
    trigDataSize = 5'd16;
    trigHits     = 16'hA5C3;
    @(posedge clk); #1;
    check("trig16", trigOut, 16'hA5C3);
    @(negedge clk);
    trigDataSize = 5'd1;
    @(posedge clk); #1;
    check("trig1", trigOut, 16'h0001);
    @(negedge clk);
    trigDataSize = 5'd0;
    @(posedge clk); #1;
    check("trig0", trigOut, 16'h0000);
`else
    @(negedge clk);
    trigDataSize = 5'd4;
    trigHits     = 16'hFFFF;
    @(posedge clk); #1;
    check("trig_off", trigOut, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/global_hit_reader.md
Name: global_hit_reader

Overview:
- Global-side reader of the pixel readout tree; it is the consumer at the downstream port of the column data-source switchers.
- Per accepted L1 event it:
  - broadcasts the event tag on dnBCST,
  - waits for the pixel match logic to settle,
  - pops matched hits one at a time through the dnUnreadHit/dnRead handshake,
  - emits a framed stream (header, hits, trailer) toward the frame builder.
- It also optionally registers trigger hits for the trigger path.

Parameters:
- BCSTWIDTH, 27: broadcast width; bit [BCSTWIDTH-1] = read-active flag, bits [BCSTWIDTH-2:0] = event tag. Legal range 2..38.
- SETTLE_CYC, 2: cycles to wait after the tag is broadcast before the first dnUnreadHit sample. Legal range 1..15.
- MAXHITS, 255: maximum hits read per event. Legal range 1..255.

Ports:
- clk  in  1  readout clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- l1aValid  in  1  accepted-L1 request.
- l1aTag  in  BCSTWIDTH-1  event tag for the request.
- l1aReady  out  1  high only in IDLE.
- dnData  in  46  hit word from the switcher tree.
- dnUnreadHit  in  1  at least one matched hit remains.
- dnRead  out  1  one-cycle pop strobe toward the pixels.
- dnBCST  out  BCSTWIDTH  broadcast {active, tag}.
- outData  out  48  {type[1:0], payload[45:0]}.
- outValid  out  1  output word valid.
- outReady  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- trigDataSize  in  5  number of valid trigger bits: 0, 1, 2, 4, 8 or 16.
- trigHits  in  16  trigger hit bits from the switcher.
- trigOut  out  16  registered, masked trigger hits.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE; l1aReady = 1 after reset.
  - dnRead = 0, dnBCST = 0, outValid = 0, outData = 0, busy = 0, trigOut = 0.
  - tag register = 0, hit count = 0, truncate flag = 0.
- Word types:
  - 2'b10 header, payload {zeros, tag}.
  - 2'b00 hit, payload = dnData.
  - 2'b11 trailer, payload {zeros, trunc(1), hitCount(8), tag}.
  - Unused payload MSBs are 0.
- Handshake:
  - A word transfers on a cycle with outValid & outReady.
  - outData is held stable while outValid is high and outReady is low.
- FSM:
  - IDLE:
    - l1aReady = 1.
    - On l1aValid: latch tag, clear count and trunc, go to HDR.
  - HDR:
    - Present the header.
    - On transfer: dnBCST <= {1, tag}, go to SETTLE.
  - SETTLE:
    - Wait SETTLE_CYC cycles, then go to CHECK.
  - CHECK (one cycle, outValid = 0):
    - dnUnreadHit = 0: go to TRL.
    - Otherwise, count == MAXHITS: set trunc, go to TRL.
    - Otherwise: go to HIT.
  - HIT:
    - Present the hit word; outData = dnData, sampled live.
    - dnRead = outValid & outReady (combinational); it pulses exactly on the transfer cycle.
    - On transfer: count++, go to GAP.
  - GAP:
    - Exactly 1 cycle so the switcher chain can update, then go to CHECK.
  - TRL:
    - Present the trailer.
    - On transfer: dnBCST[BCSTWIDTH-1] <= 0 (tag bits keep the last tag), go to IDLE.
- Throughput: at most one hit every 3 cycles (HIT, GAP, CHECK) when outReady is held high.
- Empty event: the output is header then trailer with count = 0.
- Truncation: when MAXHITS is reached, remaining pixel hits are not drained. They stay in the pixel buffers and are not popped.
- dnRead is never asserted outside HIT and never for 2 consecutive cycles.
- l1aValid in any state other than IDLE is ignored. Upstream holds the request.
- Reset mid-event: immediate return to IDLE, dnBCST active bit cleared, no trailer emitted.

Optional Feature:
- Macro: TRIG_CAPTURE_EN.
- Defined:
  - Each cycle trigOut <= trigHits & mask, where mask has the low trigDataSize bits set.
  - 1-cycle latency.
  - trigDataSize = 0, or any value other than 0/1/2/4/8/16, gives trigOut = 0.
- Undefined:
  - trigOut is constant 0.
  - trigHits and trigDataSize are ignored.
  - No capture flops are synthesised.

Test Plan:
- l1aTag = 26'h155, dnUnreadHit = 0, outReady = 1 -> exactly 2 words out:
  - header {2'b10, 20'd0, 26'h155},
  - trailer with count = 0, trunc = 0;
  - dnRead never pulses.
- 3 pixel hits A/B/C queued, outReady = 1:
  - output = header, A, B, C, trailer(count 3);
  - dnRead pulses exactly 3 times;
  - no two pulses within 3 cycles of each other;
  - dnBCST = {1, tag} from header transfer until trailer transfer.
- MAXHITS = 2, 5 hits queued:
  - output = header, 2 hits, trailer(trunc 1, count 2);
  - 3 hits remain, dnUnreadHit still 1 at exit.
- Random outReady backpressure with 4 hits:
  - outData stable while stalled;
  - dnRead only on transfer cycles;
  - all 4 hits delivered in order.
- rstn pulsed low during HIT:
  - all outputs zero asynchronously;
  - after release, a new l1a gives a clean header.
- TRIG_CAPTURE_EN defined, trigDataSize = 4, trigHits = 16'hFFFF -> trigOut = 16'h000F one cycle later.
- Same stimulus with trigDataSize = 3 -> trigOut = 0.
